// File: rtl/riscv_apu_wb_buffer.sv
// APU result write-back buffer: retires APU results on RF port B behind LSU priority,
// queueing blocked results in a small FIFO and flagging hazards against queued destinations.
module riscv_apu_wb_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned FLAG_WIDTH = 5,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       apu_valid_i,
  input  logic [DATA_WIDTH-1:0]      apu_result_i,
  input  logic [FLAG_WIDTH-1:0]      apu_flags_i,
  input  logic [ADDR_WIDTH-1:0]      apu_waddr_i,
  input  logic                       lsu_we_i,
  output logic                       rf_we_o,
  output logic [ADDR_WIDTH-1:0]      rf_waddr_o,
  output logic [DATA_WIDTH-1:0]      rf_wdata_o,
  output logic                       fflags_we_o,
  output logic [FLAG_WIDTH-1:0]      fflags_o,
  input  logic [2:0][ADDR_WIDTH-1:0] read_regs_i,
  input  logic [2:0]                 read_regs_valid_i,
  output logic                       read_dep_o,
  input  logic [1:0][ADDR_WIDTH-1:0] write_regs_i,
  input  logic [1:0]                 write_regs_valid_i,
  output logic                       write_dep_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [FLAG_WIDTH-1:0] flags_q [DEPTH];
  logic [ADDR_WIDTH-1:0] waddr_q [DEPTH];

  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic empty, full, port_free, pop, bypass, push, drop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign port_free = !lsu_we_i && !rst_i;
  assign pop       = !empty && port_free;
  assign bypass    = empty && apu_valid_i && port_free;
  // A full FIFO still accepts when its head retires in the same cycle.
  assign push      = apu_valid_i && !bypass && (!full || pop);
  assign drop      = apu_valid_i && !bypass && full && !pop;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    fflags_o   = '0;
    if (pop) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = waddr_q[rptr_q];
      rf_wdata_o = data_q[rptr_q];
      fflags_o   = flags_q[rptr_q];
    end else if (bypass) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = apu_waddr_i;
      rf_wdata_o = apu_result_i;
      fflags_o   = apu_flags_i;
    end
  end

  assign fflags_we_o = rf_we_o;

  // An entry is occupied when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] offset;
    read_dep_o  = 1'b0;
    write_dep_o = 1'b0;
    offset      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rptr_q;
      if ({1'b0, offset} < count_q) begin
        for (int unsigned j = 0; j < 3; j++)
          if (read_regs_valid_i[j] && (read_regs_i[j] == waddr_q[i])) read_dep_o = 1'b1;
        for (int unsigned j = 0; j < 2; j++)
          if (write_regs_valid_i[j] && (write_regs_i[j] == waddr_q[i])) write_dep_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      if (push && !pop)      count_q <= count_q + CNT_ONE;
      else if (pop && !push) count_q <= count_q - CNT_ONE;
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      data_q[wptr_q]  <= apu_result_i;
      flags_q[wptr_q] <= apu_flags_i;
      waddr_q[wptr_q] <= apu_waddr_i;
    end
  end

  assign empty_o    = empty;
  assign full_o     = full;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_riscv_apu_wb_buffer.sv
// Directed self-checking bench for riscv_apu_wb_buffer (DEPTH=2).
module tb_riscv_apu_wb_buffer;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            apu_valid_i;
  logic [31:0]     apu_result_i;
  logic [4:0]      apu_flags_i;
  logic [5:0]      apu_waddr_i;
  logic            lsu_we_i;
  logic            rf_we_o;
  logic [5:0]      rf_waddr_o;
  logic [31:0]     rf_wdata_o;
  logic            fflags_we_o;
  logic [4:0]      fflags_o;
  logic [2:0][5:0] read_regs_i;
  logic [2:0]      read_regs_valid_i;
  logic            read_dep_o;
  logic [1:0][5:0] write_regs_i;
  logic [1:0]      write_regs_valid_i;
  logic            write_dep_o;
  logic            empty_o, full_o, overflow_o;

  int unsigned total = 0;
  int unsigned passed = 0;

  riscv_apu_wb_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .FLAG_WIDTH(5), .DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .apu_valid_i(apu_valid_i), .apu_result_i(apu_result_i),
    .apu_flags_i(apu_flags_i), .apu_waddr_i(apu_waddr_i), .lsu_we_i(lsu_we_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .fflags_we_o(fflags_we_o), .fflags_o(fflags_o), .read_regs_i(read_regs_i),
    .read_regs_valid_i(read_regs_valid_i), .read_dep_o(read_dep_o), .write_regs_i(write_regs_i),
    .write_regs_valid_i(write_regs_valid_i), .write_dep_o(write_dep_o), .empty_o(empty_o),
    .full_o(full_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge, then apply one cycle of inputs.
  task automatic drive(input logic lsu, input logic vld, input logic [5:0] addr, input logic [31:0] data,
                       input logic [4:0] flg);
    @(posedge clk_i); #1;
    lsu_we_i = lsu; apu_valid_i = vld; apu_waddr_i = addr; apu_result_i = data; apu_flags_i = flg;
    #2;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; lsu_we_i = 1'b0; apu_valid_i = 1'b0; apu_waddr_i = '0; apu_result_i = '0;
    apu_flags_i = '0; read_regs_i = '0; read_regs_valid_i = '0; write_regs_i = '0; write_regs_valid_i = '0;
    repeat (2) @(posedge clk_i);
    #2;
    total++; if (empty_o !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty_o); else passed++;
    total++; if ({rf_we_o, full_o, overflow_o, read_dep_o, write_dep_o} !== 5'b0)
      $display("FAIL reset_outs got %b exp 00000", {rf_we_o, full_o, overflow_o, read_dep_o, write_dep_o}); else passed++;
    total++; if ({rf_waddr_o, rf_wdata_o, fflags_o} !== '0)
      $display("FAIL reset_data got %h exp 0", {rf_waddr_o, rf_wdata_o, fflags_o}); else passed++;
    @(posedge clk_i); #1 rst_i = 1'b0;
  endtask

  task automatic test_bypass;
    drive(1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 5'h03);
    total++; if ({rf_we_o, fflags_we_o, rf_waddr_o} !== {2'b11, 6'd5})
      $display("FAIL bypass_we_addr got %b/%b/%0d exp 1/1/5", rf_we_o, fflags_we_o, rf_waddr_o); else passed++;
    total++; if ({rf_wdata_o, fflags_o} !== {32'hDEADBEEF, 5'h03})
      $display("FAIL bypass_data got %h/%h exp deadbeef/03", rf_wdata_o, fflags_o); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_we_o, empty_o, rf_waddr_o} !== {2'b01, 6'd0})
      $display("FAIL bypass_after got we=%b empty=%b addr=%0d exp 0/1/0", rf_we_o, empty_o, rf_waddr_o); else passed++;
  endtask

  task automatic test_blocked;
    drive(1'b1, 1'b1, 6'd3, 32'h33, 5'h01);
    total++; if (rf_we_o !== 1'b0) $display("FAIL blocked_no_we got %b exp 0", rf_we_o); else passed++;
    drive(1'b1, 1'b1, 6'd4, 32'h44, 5'h02);
    total++; if ({empty_o, full_o} !== 2'b00) $display("FAIL blocked_one got e/f=%b exp 00", {empty_o, full_o}); else passed++;
    drive(1'b1, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if (full_o !== 1'b1) $display("FAIL blocked_full got %b exp 1", full_o); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o, fflags_o} !== {1'b1, 6'd3, 32'h33, 5'h01})
      $display("FAIL blocked_r3 got we=%b addr=%0d data=%h fl=%h exp 1/3/33/01", rf_we_o, rf_waddr_o, rf_wdata_o, fflags_o); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o, full_o} !== {1'b1, 6'd4, 32'h44, 1'b0})
      $display("FAIL blocked_r4 got we=%b addr=%0d data=%h full=%b exp 1/4/44/0", rf_we_o, rf_waddr_o, rf_wdata_o, full_o); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_we_o, empty_o} !== 2'b01) $display("FAIL blocked_drained got we/empty=%b exp 01", {rf_we_o, empty_o}); else passed++;
  endtask

  task automatic test_push_pop;
    drive(1'b1, 1'b1, 6'd7, 32'h77, 5'h07);
    drive(1'b0, 1'b1, 6'd8, 32'h88, 5'h08);
    total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 6'd7, 32'h77})
      $display("FAIL pushpop_r7 got we=%b addr=%0d data=%h exp 1/7/77", rf_we_o, rf_waddr_o, rf_wdata_o); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o, empty_o, full_o} !== {1'b1, 6'd8, 32'h88, 2'b00})
      $display("FAIL pushpop_r8 got we=%b addr=%0d data=%h e/f=%b%b exp 1/8/88/00", rf_we_o, rf_waddr_o, rf_wdata_o, empty_o, full_o); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_we_o, empty_o} !== 2'b01) $display("FAIL pushpop_drained got we/empty=%b exp 01", {rf_we_o, empty_o}); else passed++;
  endtask

  task automatic test_hazard;
    drive(1'b1, 1'b1, 6'd9, 32'h99, 5'h09);
    drive(1'b1, 1'b0, 6'd0, 32'h0, 5'h0);
    read_regs_i = {6'd0, 6'd9, 6'd1}; read_regs_valid_i = 3'b010; #1;
    total++; if (read_dep_o !== 1'b1) $display("FAIL hazard_read got %b exp 1", read_dep_o); else passed++;
    read_regs_valid_i = 3'b101; #1;
    total++; if (read_dep_o !== 1'b0) $display("FAIL hazard_read_invalid got %b exp 0", read_dep_o); else passed++;
    write_regs_i = {6'd2, 6'd9}; write_regs_valid_i = 2'b01; #1;
    total++; if (write_dep_o !== 1'b1) $display("FAIL hazard_write got %b exp 1", write_dep_o); else passed++;
    write_regs_i = {6'd9, 6'd2}; #1;
    total++; if (write_dep_o !== 1'b0) $display("FAIL hazard_write_invalid got %b exp 0", write_dep_o); else passed++;
    // Popping entry still reports a hazard this cycle.
    lsu_we_i = 1'b0; read_regs_valid_i = 3'b010; #1;
    total++; if ({rf_we_o, read_dep_o} !== 2'b11) $display("FAIL hazard_popping got we/dep=%b exp 11", {rf_we_o, read_dep_o}); else passed++;
    drive(1'b0, 1'b1, 6'd9, 32'h123, 5'h0);
    total++; if ({rf_we_o, read_dep_o, write_dep_o} !== 3'b100)
      $display("FAIL hazard_bypass_excluded got we/rd/wr=%b exp 100", {rf_we_o, read_dep_o, write_dep_o}); else passed++;
    read_regs_valid_i = '0; write_regs_valid_i = '0;
  endtask

  task automatic test_overflow;
    drive(1'b1, 1'b1, 6'd10, 32'hA, 5'h0);
    drive(1'b1, 1'b1, 6'd11, 32'hB, 5'h0);
    drive(1'b1, 1'b1, 6'd12, 32'hC, 5'h0);
    total++; if ({full_o, overflow_o} !== 2'b10) $display("FAIL ovf_before got f/o=%b exp 10", {full_o, overflow_o}); else passed++;
    drive(1'b1, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({full_o, overflow_o} !== 2'b11) $display("FAIL ovf_set got f/o=%b exp 11", {full_o, overflow_o}); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_we_o, rf_waddr_o} !== {1'b1, 6'd10}) $display("FAIL ovf_r10 got we=%b addr=%0d exp 1/10", rf_we_o, rf_waddr_o); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_we_o, rf_waddr_o, overflow_o} !== {1'b1, 6'd11, 1'b1})
      $display("FAIL ovf_r11 got we=%b addr=%0d ovf=%b exp 1/11/1", rf_we_o, rf_waddr_o, overflow_o); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_we_o, empty_o, overflow_o} !== 3'b011) $display("FAIL ovf_no_r12 got we/e/o=%b exp 011", {rf_we_o, empty_o, overflow_o}); else passed++;
    // Full with a pop in the same cycle accepts the new result.
    drive(1'b1, 1'b1, 6'd20, 32'h20, 5'h0);
    drive(1'b1, 1'b1, 6'd21, 32'h21, 5'h0);
    drive(1'b0, 1'b1, 6'd22, 32'h22, 5'h0);
    total++; if ({rf_we_o, rf_waddr_o, full_o} !== {1'b1, 6'd20, 1'b1}) $display("FAIL full_pop_r20 got we=%b addr=%0d full=%b exp 1/20/1", rf_we_o, rf_waddr_o, full_o); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_waddr_o, full_o} !== {6'd21, 1'b1}) $display("FAIL full_pop_r21 got addr=%0d full=%b exp 21/1", rf_waddr_o, full_o); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 6'd22, 32'h22}) $display("FAIL full_pop_r22 got we=%b addr=%0d data=%h exp 1/22/22", rf_we_o, rf_waddr_o, rf_wdata_o); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_we_o, empty_o} !== 2'b01) $display("FAIL full_pop_drained got we/empty=%b exp 01", {rf_we_o, empty_o}); else passed++;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 1'b1, 6'd1, 32'h1, 5'h0);
    drive(1'b1, 1'b1, 6'd2, 32'h2, 5'h0);
    drive(1'b1, 1'b0, 6'd0, 32'h0, 5'h0);
    lsu_we_i = 1'b0; #1;
    total++; if ({rf_we_o, rf_waddr_o, full_o} !== {1'b1, 6'd1, 1'b1}) $display("FAIL rstmid_pre got we=%b addr=%0d full=%b exp 1/1/1", rf_we_o, rf_waddr_o, full_o); else passed++;
    rst_i = 1'b1; #1;
    total++; if ({rf_we_o, empty_o, full_o, overflow_o} !== 4'b0100)
      $display("FAIL rstmid_async got we/e/f/o=%b exp 0100", {rf_we_o, empty_o, full_o, overflow_o}); else passed++;
    @(posedge clk_i); #1 rst_i = 1'b0; #2;
    total++; if ({rf_we_o, empty_o, rf_waddr_o} !== {2'b01, 6'd0}) $display("FAIL rstmid_after got we=%b empty=%b addr=%0d exp 0/1/0", rf_we_o, empty_o, rf_waddr_o); else passed++;
    drive(1'b0, 1'b0, 6'd0, 32'h0, 5'h0);
    total++; if ({rf_we_o, empty_o} !== 2'b01) $display("FAIL rstmid_stays got we/empty=%b exp 01", {rf_we_o, empty_o}); else passed++;
  endtask

  initial begin
    test_reset;
    test_bypass;
    test_blocked;
    test_push_pop;
    test_hazard;
    test_overflow;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
